shift_unit_arbiter: RTL and testbench

- Shares one 32-bit barrel shift unit among NREQ requesters, e.g. the EX-stage ALU path and a multi-cycle multiply/divide sequencer.
- Arbitration is round-robin.
- Each requester uses a valid/ready handshake.
- The shift result is held in a single registered output slot with its own valid/ready handshake, giving 1-cycle latency and throughput of one shift per cycle.

---
 rtl/shift_unit_arbiter.sv | 118 +++++++++++
 tb/tb_shift_unit_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter
// Round-robin arbiter that shares one 32-bit barrel shifter among NREQ
// requesters. The winning request is shifted combinationally and captured
// into a single registered result slot with its own valid/ready handshake.
module shift_unit_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*5-1:0]    req_shamt,
  input  logic [NREQ*2-1:0]    req_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id
);

  logic [IDW-1:0] rr_ptr;
  logic           slot_free;
  logic           transfer;
  logic           hi_found;
  logic           lo_found;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [31:0]    grant_a;
  logic [4:0]     grant_shamt;
  logic [1:0]     grant_sel;
  logic [31:0]    shift_result;

  // The slot can take a new result when empty or when it drains this cycle.
  assign slot_free = !rsp_valid || rsp_ready;

  // Circular priority search: lowest valid index at or above rr_ptr wins,
  // otherwise the lowest valid index overall (the wrap-around case).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
  end

  assign grant_found = hi_found || lo_found;
  assign grant_idx   = hi_found ? hi_idx : lo_idx;
  assign transfer    = rst_n && slot_free && grant_found;

  // One-hot grant back to the winning requester; silent during reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (transfer && (grant_idx == IDW'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  // Route the granted requester's operands to the shared shifter.
  always_comb begin
    grant_a     = '0;
    grant_shamt = '0;
    grant_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        grant_a     = req_a[32*i +: 32];
        grant_shamt = req_shamt[5*i +: 5];
        grant_sel   = req_sel[2*i +: 2];
      end
    end
  end

  // The shared barrel shifter: SRL, SLL, SRA or pass-through.
  always_comb begin
    shift_result = grant_a;
    case (grant_sel)
      2'b00:   shift_result = grant_a >> grant_shamt;
      2'b01:   shift_result = grant_a << grant_shamt;
      2'b10:   shift_result = $unsigned($signed(grant_a) >>> grant_shamt);
      default: shift_result = grant_a;
    endcase
  end

  // Result slot and round-robin pointer; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (transfer) begin
      rsp_valid <= 1'b1;
      rsp_data  <= shift_result;
      rsp_id    <= grant_idx;
      if (grant_idx == IDW'(NREQ - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= grant_idx + IDW'(1);
      end
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb_shift_unit_arbiter
// Scenario tasks for the shift unit arbiter with three requesters, checked
// against constants and a behavioural model of the arbiter and shifter.
module tb_shift_unit_arbiter;

  localparam int NREQ = 3;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_a;
  logic [NREQ*5-1:0]   req_shamt;
  logic [NREQ*2-1:0]   req_sel;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic [IDW-1:0]      rsp_id;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic           m_valid = 1'b0;
  logic [31:0]    m_data  = '0;
  logic [IDW-1:0] m_id    = '0;
  int             m_ptr   = 0;
  int             last_grant = -1;

  shift_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_shamt (req_shamt),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  // Shift by arithmetic: division/multiplication by a power of two.
  function automatic logic [31:0] model_shift(input logic [31:0] a, input int sh,
                                              input logic [1:0] op);
    longint unsigned p;
    logic [31:0] na;
    p  = 64'd1 << sh;
    na = ~a;
    case (op)
      2'b00:   return 32'(64'(a) / p);
      2'b01:   return 32'(64'(a) * p);
      2'b10:   return a[31] ? ~32'(64'(na) / p) : 32'(64'(a) / p);
      default: return a;
    endcase
  endfunction

  // Which requester the rules say wins right now, or -1 for none.
  function automatic int model_grant();
    int idx;
    if (rst_n !== 1'b1) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    int g;
    g = model_grant();
    if (g < 0) return '0;
    return NREQ'(1) << g;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [4:0] sh,
                         input logic [1:0] op);
    req_a[32*i +: 32]    = a;
    req_shamt[5*i +: 5]  = sh;
    req_sel[2*i +: 2]    = op;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic cycle();
    int g;
    g = model_grant();
    @(posedge clk);
    last_grant = g;
    if (rst_n !== 1'b1) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_id    = '0;
      m_ptr   = 0;
    end else if (g >= 0) begin
      m_data  = model_shift(req_a[32*g +: 32], int'(req_shamt[5*g +: 5]), req_sel[2*g +: 2]);
      m_id    = g[IDW-1:0];
      m_valid = 1'b1;
      m_ptr   = (g + 1) % NREQ;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    set_req(0, 32'h1234_5678, 5'd4, 2'b00);
    req_valid = 3'b001;
    cycle();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_valid: got %b want 1", rsp_valid); end
    rst_n = 1'b0;
    req_valid = 3'b111;
    set_req(1, 32'h0000_00FF, 5'd1, 2'b01);
    set_req(2, 32'h8000_0000, 5'd2, 2'b10);
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("[TB] FAIL rst_ready_comb: got %b want 000", req_ready); end
    cycle();
    cycle();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_data: got %h want 0", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL rst_id: got %0d want 0", rsp_id); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("[TB] FAIL rst_ready: got %b want 000", req_ready); end
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("[TB] FAIL rst_first_grant: got %b want 001", req_ready); end
    cycle();
    req_valid = '0;
    checks++; if (rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_first_rsp: got id %0d valid %b want 0/1", rsp_id, rsp_valid); end
    checks++; if (rsp_data !== 32'h0123_4567) begin errors++; $display("[TB] FAIL rst_first_data: got %h want 01234567", rsp_data); end
  endtask

  task automatic test_ops();
    logic [31:0] a_tab   [5] = '{32'hF000_0001, 32'hF000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001};
    logic [4:0]  sh_tab  [5] = '{5'd4, 5'd4, 5'd31, 5'd0, 5'd7};
    logic [1:0]  op_tab  [5] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b11};
    logic [31:0] exp_tab [5] = '{32'hFF00_0000, 32'h0F00_0000, 32'h8000_0000, 32'h8000_0001, 32'h8000_0001};
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 3'b001;
    for (int t = 0; t < 5; t++) begin
      set_req(0, a_tab[t], sh_tab[t], op_tab[t]);
      #1;
      checks++; if (req_ready !== 3'b001) begin errors++; $display("[TB] FAIL ops_ready[%0d]: got %b want 001", t, req_ready); end
      cycle();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL ops_valid[%0d]: got %b want 1", t, rsp_valid); end
      checks++; if (rsp_data !== exp_tab[t]) begin errors++; $display("[TB] FAIL ops_data[%0d]: got %h want %h", t, rsp_data, exp_tab[t]); end
      checks++; if (rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL ops_id[%0d]: got %0d want 0", t, rsp_id); end
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    // Requesters 0 and 1 only, then all three.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      rsp_ready = 1'b1;
      set_req(0, 32'h0000_0010, 5'd1, 2'b00);
      set_req(1, 32'h0000_0010, 5'd2, 2'b01);
      set_req(2, 32'hC000_0000, 5'd3, 2'b10);
      req_valid = (pass == 0) ? 3'b011 : 3'b111;
      for (int c = 0; c < 6; c++) begin
        cycle();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rr_valid[%0d.%0d]: got %b want 1", pass, c, rsp_valid); end
        checks++; if (int'(rsp_id) != ((pass == 0) ? c % 2 : c % 3)) begin errors++; $display("[TB] FAIL rr_id[%0d.%0d]: got %0d want %0d", pass, c, rsp_id, (pass == 0) ? c % 2 : c % 3); end
        checks++; if (rsp_data !== m_data) begin errors++; $display("[TB] FAIL rr_data[%0d.%0d]: got %h want %h", pass, c, rsp_data, m_data); end
      end
      req_valid = '0;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 32'h0000_00F0, 5'd4, 2'b00);
    req_valid = 3'b001;
    cycle();
    set_req(0, 32'hAAAA_0000, 5'd16, 2'b00);
    set_req(1, 32'h0000_0001, 5'd8, 2'b01);
    req_valid = 3'b011;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 3'b000) begin errors++; $display("[TB] FAIL bp_ready[%0d]: got %b want 000", c, req_ready); end
      cycle();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL bp_hold_id[%0d]: got valid %b id %0d want 1/0", c, rsp_valid, rsp_id); end
      checks++; if (rsp_data !== 32'h0000_000F) begin errors++; $display("[TB] FAIL bp_hold_data[%0d]: got %h want 0000000f", c, rsp_data); end
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("[TB] FAIL bp_release_ready: got %b want 010", req_ready); end
    cycle();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("[TB] FAIL bp_refill_id: got valid %b id %0d want 1/1", rsp_valid, rsp_id); end
    checks++; if (rsp_data !== 32'h0000_0100) begin errors++; $display("[TB] FAIL bp_refill_data: got %h want 00000100", rsp_data); end
    req_valid = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("[TB] FAIL bp_next_ready: got %b want 001", req_ready); end
    cycle();
    checks++; if (rsp_data !== 32'h0000_AAAA || rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL bp_next: got %h id %0d want 0000aaaa/0", rsp_data, rsp_id); end
    req_valid = '0;
  endtask

  task automatic test_wrap_skip();
    int exp_g [3] = '{2, 0, 2};
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 32'h0000_0011, 5'd0, 2'b11);
    set_req(1, 32'h0000_00BB, 5'd0, 2'b11);
    set_req(2, 32'h0000_0022, 5'd0, 2'b11);
    req_valid = 3'b001;
    cycle();
    req_valid = 3'b101;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== (3'b001 << exp_g[c])) begin errors++; $display("[TB] FAIL wrap_ready[%0d]: got %b want %b", c, req_ready, 3'b001 << exp_g[c]); end
      cycle();
      checks++; if (int'(rsp_id) != exp_g[c]) begin errors++; $display("[TB] FAIL wrap_id[%0d]: got %0d want %0d", c, rsp_id, exp_g[c]); end
      checks++; if (rsp_data !== ((exp_g[c] == 2) ? 32'h22 : 32'h11)) begin errors++; $display("[TB] FAIL wrap_data[%0d]: got %h", c, rsp_data); end
    end
    req_valid = '0;
  endtask

  task automatic test_drain();
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 32'hDEAD_BEEF, 5'd8, 2'b01);
    req_valid = 3'b001;
    cycle();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hADBE_EF00) begin errors++; $display("[TB] FAIL drain_first: got %b %h want 1 adbeef00", rsp_valid, rsp_data); end
    cycle();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 32'hADBE_EF00 || rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL drain_hold: got %h id %0d want adbeef00/0", rsp_data, rsp_id); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && last_grant != i)) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          set_req(i, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      #1;
      checks++; if (req_ready !== model_ready()) begin errors++; $display("[TB] FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, model_ready()); end
      checks++; if (rsp_valid !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid[%0d]: got %b want %b", c, rsp_valid, m_valid); end
      checks++; if (rsp_data !== m_data || rsp_id !== m_id) begin errors++; $display("[TB] FAIL rnd_rsp[%0d]: got %h/%0d want %h/%0d", c, rsp_data, rsp_id, m_data, m_id); end
      cycle();
    end
    req_valid = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_shamt = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_ops();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
